// File: rtl/rename_stage_if.sv
// rename_stage_if: decode-in, dispatch-out, commit and flush signals of the rename stage.
// master = environment (decode/dispatch/commit side); slave = the rename stage itself.
// Parameters must match those of the rename_stage instance using it.
interface rename_stage_if #(
  parameter int MAX_OPERANDS = 3,
  parameter int ARN_BITS     = 6,
  parameter int PRN_BITS     = 7,
  parameter int FU_COUNT     = 4
);
  localparam int FUC_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  // decode -> rename
  logic                                   in_valid;
  logic [31:0]                            in_raw_instr;
  logic [63:0]                            in_pc;
  logic [FUC_BITS-1:0]                    in_fu_choice;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  in_arn_inputs;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  in_arn_outputs;
  logic                                   stall_out;

  // rename -> dispatch
  logic                                   out_valid;
  logic [31:0]                            out_raw_instr;
  logic [63:0]                            out_pc;
  logic [FUC_BITS-1:0]                    out_fu_choice;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn_inputs;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn_outputs;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn_old;
  logic                                   stall_in;

  // commit / redirect
  logic [MAX_OPERANDS-1:0]                commit_valid;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  commit_arn;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  commit_prn;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  commit_old_prn;
  logic                                   flush;

  modport master (
    output in_valid, in_raw_instr, in_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
    output stall_in, commit_valid, commit_arn, commit_prn, commit_old_prn, flush,
    input  stall_out, out_valid, out_raw_instr, out_pc, out_fu_choice,
    input  out_prn_inputs, out_prn_outputs, out_prn_old
  );

  modport slave (
    input  in_valid, in_raw_instr, in_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
    input  stall_in, commit_valid, commit_arn, commit_prn, commit_old_prn, flush,
    output stall_out, out_valid, out_raw_instr, out_pc, out_fu_choice,
    output out_prn_inputs, out_prn_outputs, out_prn_old
  );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: maps architectural to physical registers via a speculative RAT, circular free list
// and retirement RAT. Ports: clk, rst_n (async active-low), io (rename_stage_if.slave).
// Latency 1 cycle (registered outputs); stall_out is raised when dispatch stalls a valid output
// or the free list cannot cover this instruction's destinations.
module rename_stage #(
  parameter int MAX_OPERANDS = 3,
  parameter int ARN_BITS     = 6,
  parameter int PRN_BITS     = 7,
  parameter int FU_COUNT     = 4
) (
  input logic           clk,
  input logic           rst_n,
  rename_stage_if.slave io
);
  localparam int FUC_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int DEPTH    = 2 ** ARN_BITS;
  localparam int CNT_BITS = ARN_BITS + 1;

  typedef logic [ARN_BITS-1:0]                    arn_t;
  typedef logic [PRN_BITS-1:0]                    prn_t;
  typedef logic [ARN_BITS-1:0]                    ptr_t;
  typedef logic [CNT_BITS-1:0]                    cnt_t;
  typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_vec_t;

  localparam arn_t ARN_NONE = '1;
  localparam prn_t PRN_NONE = '1;

  prn_t spec_rat_q   [DEPTH];
  prn_t spec_rat_d   [DEPTH];
  prn_t retire_rat_q [DEPTH];
  prn_t retire_rat_d [DEPTH];
  prn_t fl_q         [DEPTH];
  prn_t fl_d         [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t commit_head_q, commit_head_d;
  cnt_t count_q, count_d;

  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_raw_instr_q, out_raw_instr_d;
  logic [63:0]         out_pc_q, out_pc_d;
  logic [FUC_BITS-1:0] out_fu_choice_q, out_fu_choice_d;
  prn_vec_t            out_prn_inputs_q, out_prn_inputs_d;
  prn_vec_t            out_prn_outputs_q, out_prn_outputs_d;
  prn_vec_t            out_prn_old_q, out_prn_old_d;

  cnt_t need, pops, pushes;
  ptr_t flush_gap;
  logic stall, accept;

  always_comb begin : need_calc
    need = '0;
    for (int i = 0; i < MAX_OPERANDS; i++)
      if (io.in_arn_outputs[i] != ARN_NONE) need = need + cnt_t'(1);
  end

  // Uses the pre-cycle count: PRNs pushed by a same-cycle commit are not usable until next cycle.
  assign stall  = (out_valid_q && io.stall_in) || (count_q < need);
  assign accept = io.in_valid && !stall && !io.flush;

  always_comb begin : next_state
    spec_rat_d        = spec_rat_q;
    retire_rat_d      = retire_rat_q;
    fl_d              = fl_q;
    head_d            = head_q;
    tail_d            = tail_q;
    commit_head_d     = commit_head_q;
    pops              = '0;
    pushes            = '0;
    flush_gap         = '0;
    out_valid_d       = out_valid_q;
    out_raw_instr_d   = out_raw_instr_q;
    out_pc_d          = out_pc_q;
    out_fu_choice_d   = out_fu_choice_q;
    out_prn_inputs_d  = out_prn_inputs_q;
    out_prn_outputs_d = out_prn_outputs_q;
    out_prn_old_d     = out_prn_old_q;

    // Commit: retire mapping, return superseded PRN at tail, track retired allocation point.
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (io.commit_valid[i]) begin
        retire_rat_d[io.commit_arn[i]] = io.commit_prn[i];
        if (io.commit_old_prn[i] != PRN_NONE) begin
          fl_d[tail_d] = io.commit_old_prn[i];
          tail_d       = tail_d + ptr_t'(1);
          pushes       = pushes + cnt_t'(1);
        end
        if (io.commit_prn[i] != PRN_NONE) commit_head_d = commit_head_d + ptr_t'(1);
      end
    end

    if (accept) begin
      out_valid_d     = 1'b1;
      out_raw_instr_d = io.in_raw_instr;
      out_pc_d        = io.in_pc;
      out_fu_choice_d = io.in_fu_choice;
      // Sources see the RAT before this instruction's own destination writes.
      for (int i = 0; i < MAX_OPERANDS; i++)
        out_prn_inputs_d[i] = (io.in_arn_inputs[i] == ARN_NONE) ? PRN_NONE
                                                                : spec_rat_q[io.in_arn_inputs[i]];
      // Destinations in slot order; reading spec_rat_d chains duplicate ARNs.
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (io.in_arn_outputs[i] == ARN_NONE) begin
          out_prn_outputs_d[i] = PRN_NONE;
          out_prn_old_d[i]     = PRN_NONE;
        end else begin
          out_prn_outputs_d[i]               = fl_q[head_d];
          out_prn_old_d[i]                   = spec_rat_d[io.in_arn_outputs[i]];
          spec_rat_d[io.in_arn_outputs[i]]   = fl_q[head_d];
          head_d                             = head_d + ptr_t'(1);
          pops                               = pops + cnt_t'(1);
        end
      end
    end else if (!io.stall_in || io.flush) begin
      out_valid_d = 1'b0;
    end

    count_d = count_q - pops + pushes;

    if (io.flush) begin
      // Roll back to the retired state. With 63 PRNs held by the retire RAT the remaining
      // 64 are all free, so coincident pointers mean a full list, never an empty one.
      spec_rat_d = retire_rat_d;
      head_d     = commit_head_d;
      flush_gap  = tail_d - head_d;
      count_d    = (flush_gap == '0) ? cnt_t'(DEPTH) : cnt_t'(flush_gap);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        spec_rat_q[i]   <= prn_t'(i);
        retire_rat_q[i] <= prn_t'(i);
        fl_q[i]         <= prn_t'(DEPTH - 1 + i);
      end
      head_q            <= '0;
      tail_q            <= '0;
      commit_head_q     <= '0;
      count_q           <= cnt_t'(DEPTH);
      out_valid_q       <= 1'b0;
      out_raw_instr_q   <= '0;
      out_pc_q          <= '0;
      out_fu_choice_q   <= '0;
      out_prn_inputs_q  <= '0;
      out_prn_outputs_q <= '0;
      out_prn_old_q     <= '0;
    end else begin
      spec_rat_q        <= spec_rat_d;
      retire_rat_q      <= retire_rat_d;
      fl_q              <= fl_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      commit_head_q     <= commit_head_d;
      count_q           <= count_d;
      out_valid_q       <= out_valid_d;
      out_raw_instr_q   <= out_raw_instr_d;
      out_pc_q          <= out_pc_d;
      out_fu_choice_q   <= out_fu_choice_d;
      out_prn_inputs_q  <= out_prn_inputs_d;
      out_prn_outputs_q <= out_prn_outputs_d;
      out_prn_old_q     <= out_prn_old_d;
    end
  end

  assign io.stall_out       = stall;
  assign io.out_valid       = out_valid_q;
  assign io.out_raw_instr   = out_raw_instr_q;
  assign io.out_pc          = out_pc_q;
  assign io.out_fu_choice   = out_fu_choice_q;
  assign io.out_prn_inputs  = out_prn_inputs_q;
  assign io.out_prn_outputs = out_prn_outputs_q;
  assign io.out_prn_old     = out_prn_old_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed scenarios plus randomized traffic against a queue-based rename model.
// Drives rename_stage through rename_stage_if; no outputs.
// Runs a fixed number of cycles and prints a single pass-count summary.
module tb_rename_stage;
  localparam int NOPS = 3;
  localparam logic [5:0] AN = 6'd63;
  localparam logic [6:0] PN = 7'd127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_stage_if rif ();
  rename_stage dut (.clk(clk), .rst_n(rst_n), .io(rif.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct { int arn; int prn; int old; } dst_rec_t;
  int       m_spec   [64];
  int       m_retire [64];
  int       m_free[$];          // free PRNs, allocate from front, return to back
  int       m_spec_alloc[$];    // allocated but not yet committed, in allocation order
  dst_rec_t m_uncommitted[$];   // destination records awaiting commit
  logic              e_valid;
  logic [31:0]       e_raw;
  logic [63:0]       e_pc;
  logic [1:0]        e_fu;
  logic [2:0][6:0]   e_in, e_out, e_old;

  function automatic int m_need();
    int n = 0;
    for (int i = 0; i < NOPS; i++) if (rif.in_arn_outputs[i] != AN) n++;
    return n;
  endfunction

  function automatic logic m_stall();
    return (e_valid && rif.stall_in) || (m_free.size() < m_need());
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin m_spec[i] = i; m_retire[i] = i; end
    m_free.delete();
    for (int p = 63; p <= 126; p++) m_free.push_back(p);
    m_spec_alloc.delete();
    m_uncommitted.delete();
    e_valid = 1'b0; e_raw = '0; e_pc = '0; e_fu = '0; e_in = '0; e_out = '0; e_old = '0;
  endfunction

  function automatic void m_clock();
    logic acc;
    acc = rif.in_valid && !m_stall() && !rif.flush;
    for (int i = 0; i < NOPS; i++) begin
      if (rif.commit_valid[i]) begin
        m_retire[rif.commit_arn[i]] = int'(rif.commit_prn[i]);
        if (rif.commit_old_prn[i] != PN) m_free.push_back(int'(rif.commit_old_prn[i]));
        if (rif.commit_prn[i] != PN && m_spec_alloc.size() > 0) void'(m_spec_alloc.pop_front());
      end
    end
    if (acc) begin
      e_valid = 1'b1; e_raw = rif.in_raw_instr; e_pc = rif.in_pc; e_fu = rif.in_fu_choice;
      for (int i = 0; i < NOPS; i++)
        e_in[i] = (rif.in_arn_inputs[i] == AN) ? PN : 7'(m_spec[rif.in_arn_inputs[i]]);
      for (int i = 0; i < NOPS; i++) begin
        if (rif.in_arn_outputs[i] == AN) begin
          e_out[i] = PN; e_old[i] = PN;
        end else begin
          int a, p, o;
          a = int'(rif.in_arn_outputs[i]);
          p = m_free.pop_front();
          o = m_spec[a];
          m_spec[a] = p;
          e_out[i] = 7'(p); e_old[i] = 7'(o);
          m_spec_alloc.push_back(p);
          m_uncommitted.push_back('{a, p, o});
        end
      end
    end else if (!rif.stall_in || rif.flush) begin
      e_valid = 1'b0;
    end
    if (rif.flush) begin
      m_spec = m_retire;
      m_free = {m_spec_alloc, m_free};
      m_spec_alloc.delete();
      m_uncommitted.delete();
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    rif.in_valid = 1'b0; rif.in_raw_instr = '0; rif.in_pc = '0; rif.in_fu_choice = '0;
    rif.in_arn_inputs = '1; rif.in_arn_outputs = '1;
    rif.stall_in = 1'b0; rif.flush = 1'b0;
    rif.commit_valid = '0; rif.commit_arn = '0; rif.commit_prn = '0; rif.commit_old_prn = '0;
  endtask

  task automatic set_instr(input int s0, input int s1, input int s2,
                           input int d0, input int d1, input int d2);
    rif.in_valid = 1'b1;
    rif.in_raw_instr = $urandom;
    rif.in_pc = {$urandom, $urandom};
    rif.in_fu_choice = 2'($urandom_range(0, 3));
    rif.in_arn_inputs[0] = 6'(s0); rif.in_arn_inputs[1] = 6'(s1); rif.in_arn_inputs[2] = 6'(s2);
    rif.in_arn_outputs[0] = 6'(d0); rif.in_arn_outputs[1] = 6'(d1); rif.in_arn_outputs[2] = 6'(d2);
  endtask

  // Each cycle starts 1 time unit after posedge; model advances at the edge.
  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_arn();
    if ($urandom_range(0, 4) == 0) return 63;
    return int'($urandom_range(0, 11));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    set_instr(1, 63, 63, 3, 63, 63);
    tick();
    set_instr(3, 63, 63, 3, 4, 63);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rif.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rif.out_valid); else n_pass++;
    n_checks++; if (rif.out_pc !== 64'd0 || rif.out_raw_instr !== 32'd0) $display("FAIL reset_pass: got pc %h raw %h expected 0", rif.out_pc, rif.out_raw_instr); else n_pass++;
    n_checks++; if (rif.out_prn_outputs !== '0 || rif.out_prn_old !== '0 || rif.out_prn_inputs !== '0) $display("FAIL reset_prn: got %h/%h/%h expected 0", rif.out_prn_inputs, rif.out_prn_outputs, rif.out_prn_old); else n_pass++;
    n_checks++; if (rif.stall_out !== 1'b0) $display("FAIL reset_stall: got %b expected 0", rif.stall_out); else n_pass++;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd63 || rif.out_prn_outputs[1] !== 7'd64) $display("FAIL reset_realloc: got %0d,%0d expected 63,64", rif.out_prn_outputs[0], rif.out_prn_outputs[1]); else n_pass++;
    n_checks++; if (rif.out_prn_inputs[0] !== 7'd3) $display("FAIL reset_rat: got %0d expected 3", rif.out_prn_inputs[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic_rename();
    logic [2:0][6:0] x_in, x_out, x_old;
    x_in[0] = 7'd1; x_in[1] = 7'd2; x_in[2] = 7'd127;
    x_out[0] = 7'd63; x_out[1] = 7'd127; x_out[2] = 7'd127;
    x_old[0] = 7'd3; x_old[1] = 7'd127; x_old[2] = 7'd127;
    apply_reset();
    set_instr(1, 2, 63, 3, 63, 63);
    #2;
    n_checks++; if (rif.stall_out !== 1'b0) $display("FAIL basic_stall: got %b expected 0", rif.stall_out); else n_pass++;
    tick();
    n_checks++; if (rif.out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", rif.out_valid); else n_pass++;
    n_checks++; if (rif.out_prn_inputs !== x_in) $display("FAIL basic_src: got %h expected %h", rif.out_prn_inputs, x_in); else n_pass++;
    n_checks++; if (rif.out_prn_outputs !== x_out) $display("FAIL basic_dst: got %h expected %h", rif.out_prn_outputs, x_out); else n_pass++;
    n_checks++; if (rif.out_prn_old !== x_old) $display("FAIL basic_old: got %h expected %h", rif.out_prn_old, x_old); else n_pass++;
    n_checks++; if ({rif.out_raw_instr, rif.out_pc, rif.out_fu_choice} !== {e_raw, e_pc, e_fu}) $display("FAIL basic_passthru: got %h %h %h expected %h %h %h", rif.out_raw_instr, rif.out_pc, rif.out_fu_choice, e_raw, e_pc, e_fu); else n_pass++;
    idle_inputs();
    tick();
    n_checks++; if (rif.out_valid !== 1'b0) $display("FAIL basic_drop: got %b expected 0", rif.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_instr(63, 63, 63, 5, 63, 63);
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd63 || rif.out_prn_old[0] !== 7'd5) $display("FAIL b2b_a: got %0d old %0d expected 63 old 5", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    set_instr(5, 63, 63, 5, 63, 63);
    tick();
    n_checks++; if (rif.out_prn_inputs[0] !== 7'd63) $display("FAIL b2b_src: got %0d expected 63", rif.out_prn_inputs[0]); else n_pass++;
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd64 || rif.out_prn_old[0] !== 7'd63) $display("FAIL b2b_b: got %0d old %0d expected 64 old 63", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    set_instr(63, 63, 63, 5, 63, 63);
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd65 || rif.out_prn_old[0] !== 7'd64) $display("FAIL b2b_c: got %0d old %0d expected 65 old 64", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_dup_dest();
    logic [2:0][6:0] x_out, x_old;
    x_out[0] = 7'd63; x_out[1] = 7'd64; x_out[2] = 7'd127;
    x_old[0] = 7'd7;  x_old[1] = 7'd63; x_old[2] = 7'd127;
    apply_reset();
    set_instr(63, 63, 63, 7, 7, 63);
    tick();
    n_checks++; if (rif.out_prn_outputs !== x_out) $display("FAIL dup_dst: got %h expected %h", rif.out_prn_outputs, x_out); else n_pass++;
    n_checks++; if (rif.out_prn_old !== x_old) $display("FAIL dup_old: got %h expected %h", rif.out_prn_old, x_old); else n_pass++;
    set_instr(7, 63, 63, 63, 63, 63);
    tick();
    n_checks++; if (rif.out_prn_inputs[0] !== 7'd64) $display("FAIL dup_rat: got %0d expected 64", rif.out_prn_inputs[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_free_list_full();
    apply_reset();
    for (int k = 0; k < 64; k++) begin
      set_instr(63, 63, 63, 7, 63, 63);
      tick();
      n_checks++; if (rif.out_prn_outputs[0] !== 7'(63 + k)) $display("FAIL full_alloc%0d: got %0d expected %0d", k, rif.out_prn_outputs[0], 63 + k); else n_pass++;
    end
    set_instr(63, 63, 63, 7, 63, 63);
    #2;
    n_checks++; if (rif.stall_out !== 1'b1) $display("FAIL full_stall: got %b expected 1", rif.stall_out); else n_pass++;
    tick();
    n_checks++; if (rif.out_valid !== 1'b0) $display("FAIL full_noaccept: got %b expected 0", rif.out_valid); else n_pass++;
    rif.commit_valid[0] = 1'b1; rif.commit_arn[0] = 6'd7; rif.commit_prn[0] = 7'd63; rif.commit_old_prn[0] = 7'd7;
    #2;
    n_checks++; if (rif.stall_out !== 1'b1) $display("FAIL full_commit_same_cycle: got %b expected 1", rif.stall_out); else n_pass++;
    tick();
    rif.commit_valid = '0;
    #2;
    n_checks++; if (rif.stall_out !== 1'b0) $display("FAIL full_release: got %b expected 0", rif.stall_out); else n_pass++;
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd7 || rif.out_prn_old[0] !== 7'd126) $display("FAIL full_recycle: got %0d old %0d expected 7 old 126", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_in();
    logic [63:0] x_pc;
    apply_reset();
    set_instr(63, 63, 63, 9, 63, 63);
    x_pc = rif.in_pc;
    tick();
    set_instr(63, 63, 63, 9, 63, 63);
    rif.stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++; if (rif.stall_out !== 1'b1) $display("FAIL hold_stall%0d: got %b expected 1", c, rif.stall_out); else n_pass++;
      tick();
      n_checks++; if (rif.out_valid !== 1'b1 || rif.out_prn_outputs[0] !== 7'd63 || rif.out_prn_old[0] !== 7'd9 || rif.out_pc !== x_pc) $display("FAIL hold_out%0d: got v%b %0d old %0d pc %h expected v1 63 old 9 pc %h", c, rif.out_valid, rif.out_prn_outputs[0], rif.out_prn_old[0], rif.out_pc, x_pc); else n_pass++;
    end
    rif.stall_in = 1'b0;
    #2;
    n_checks++; if (rif.stall_out !== 1'b0) $display("FAIL hold_release: got %b expected 0", rif.stall_out); else n_pass++;
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd64 || rif.out_prn_old[0] !== 7'd63) $display("FAIL hold_nopop: got %0d old %0d expected 64 old 63", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    set_instr(63, 63, 63, 4, 63, 63);
    tick();
    idle_inputs();
    rif.commit_valid[0] = 1'b1; rif.commit_arn[0] = 6'd4; rif.commit_prn[0] = 7'd63; rif.commit_old_prn[0] = 7'd4;
    tick();
    rif.commit_valid = '0;
    set_instr(63, 63, 63, 4, 63, 63);
    tick();
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd64 || rif.out_prn_old[0] !== 7'd63) $display("FAIL flush_pre: got %0d old %0d expected 64 old 63", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    set_instr(4, 63, 63, 4, 63, 63);
    rif.flush = 1'b1;
    tick();
    n_checks++; if (rif.out_valid !== 1'b0) $display("FAIL flush_drop: got %b expected 0", rif.out_valid); else n_pass++;
    rif.flush = 1'b0;
    tick();
    n_checks++; if (rif.out_prn_inputs[0] !== 7'd63) $display("FAIL flush_rat: got %0d expected 63", rif.out_prn_inputs[0]); else n_pass++;
    n_checks++; if (rif.out_prn_outputs[0] !== 7'd64 || rif.out_prn_old[0] !== 7'd63) $display("FAIL flush_realloc: got %0d old %0d expected 64 old 63", rif.out_prn_outputs[0], rif.out_prn_old[0]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      set_instr(rand_arn(), rand_arn(), rand_arn(), rand_arn(), rand_arn(), rand_arn());
      rif.in_valid = ($urandom_range(0, 3) != 0);
      rif.stall_in = ($urandom_range(0, 3) == 0);
      rif.flush    = ($urandom_range(0, 39) == 0);
      rif.commit_valid = '0;
      k = int'($urandom_range(0, 3));
      if (k > m_uncommitted.size()) k = m_uncommitted.size();
      for (int i = 0; i < k; i++) begin
        dst_rec_t r;
        r = m_uncommitted.pop_front();
        rif.commit_valid[i] = 1'b1;
        rif.commit_arn[i] = 6'(r.arn);
        rif.commit_prn[i] = 7'(r.prn);
        rif.commit_old_prn[i] = 7'(r.old);
      end
      #2;
      n_checks++; if (rif.stall_out !== m_stall()) $display("FAIL rand_stall@%0d: got %b expected %b", c, rif.stall_out, m_stall()); else n_pass++;
      tick();
      n_checks++; if (rif.out_valid !== e_valid) $display("FAIL rand_valid@%0d: got %b expected %b", c, rif.out_valid, e_valid); else n_pass++;
      n_checks++;
      if ({rif.out_prn_inputs, rif.out_prn_outputs, rif.out_prn_old} !== {e_in, e_out, e_old} ||
          {rif.out_raw_instr, rif.out_pc, rif.out_fu_choice} !== {e_raw, e_pc, e_fu})
        $display("FAIL rand_data@%0d: got %h/%h/%h pc %h expected %h/%h/%h pc %h", c,
                 rif.out_prn_inputs, rif.out_prn_outputs, rif.out_prn_old, rif.out_pc,
                 e_in, e_out, e_old, e_pc);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    m_reset();
    test_reset();
    test_basic_rename();
    test_back_to_back();
    test_dup_dest();
    test_free_list_full();
    test_stall_in();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly downstream of the fetch/decode stage.
- Takes one decoded instruction per cycle (raw_instr, pc, fu_choice, architectural operand numbers) and maps architectural to physical registers through a speculative RAT and a circular free list.
- Emits renamed instructions one registered cycle later to dispatch.
- A commit port frees superseded physical registers and maintains a retirement RAT; flush restores speculative state from it.

Parameters:
MAX_OPERANDS, 3, operand slots per instruction (inputs and outputs)
ARN_BITS, 6, architectural register number width; value 2**ARN_BITS-1 (63) means "no operand"
PRN_BITS, 7, physical register number width; value 2**PRN_BITS-1 (127) means "no operand"
FU_COUNT, 4, functional units; FUC_BITS = $clog2(FU_COUNT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_raw_instr  in  32  instruction word
in_pc  in  64  instruction PC
in_fu_choice  in  FUC_BITS  FU selection
in_arn_inputs  in  MAX_OPERANDS x ARN_BITS  source ARNs
in_arn_outputs  in  MAX_OPERANDS x ARN_BITS  destination ARNs
stall_out  out  1  backpressure to decode (its stall input)
out_valid  out  1  renamed instruction valid
out_raw_instr  out  32  passthrough
out_pc  out  64  passthrough
out_fu_choice  out  FUC_BITS  passthrough
out_prn_inputs  out  MAX_OPERANDS x PRN_BITS  source PRNs
out_prn_outputs  out  MAX_OPERANDS x PRN_BITS  newly allocated destination PRNs
out_prn_old  out  MAX_OPERANDS x PRN_BITS  previous mapping of each destination, freed at commit
stall_in  in  1  dispatch cannot accept
commit_valid  in  MAX_OPERANDS  per-slot commit of one destination
commit_arn  in  MAX_OPERANDS x ARN_BITS  committed ARN
commit_prn  in  MAX_OPERANDS x PRN_BITS  committed new PRN
commit_old_prn  in  MAX_OPERANDS x PRN_BITS  PRN to return to free list
flush  in  1  mispredict/redirect, asserted with decode's set_pc_valid

Behaviour:
- Reset (async, rst_n=0):
  - Spec and retire RAT: ARN i maps to PRN i for i = 0..62.
  - Free list (depth 64) holds PRNs 63..126 in order.
  - head = commit_head = 0, tail = 0, count = 64.
  - out_valid = 0; all other outputs 0.
  - Reset mid-operation discards everything.
- need = number of in_arn_outputs != 63.
- stall_out (combinational) = (out_valid && stall_in) || (count < need).
- Acceptance: in_valid && !stall_out && !flush. On acceptance:
  - Sources: each source PRN is read from the spec RAT before this instruction's own destination writes. ARN 63 gives PRN 127.
  - Destinations: processed in ascending slot order. Each pops free_list[head]; head++ (mod 64); count--.
  - out_prn_old is the spec RAT value at the moment of that slot's write. Duplicate destination ARNs chain: the later slot's old value = the earlier slot's new PRN; the last slot's mapping remains in the RAT.
  - Destination ARN 63: no pop; out_prn_outputs and out_prn_old = 127.
  - Outputs are registered; latency is 1 cycle; out_valid = 1.
- No acceptance and !stall_in: out_valid = 0.
- stall_in with out_valid: all outputs hold.
- Commit (each slot with commit_valid, ascending order):
  - retire RAT[commit_arn] = commit_prn.
  - commit_old_prn != 127: push at tail; tail++; count++.
  - commit_head advances by 1 per slot whose commit_prn != 127.
- Same-cycle rename and commit: the stall/count check uses the count from before this cycle. Net count update = count − pops + pushes. count never exceeds 64.
- Flush, same cycle, takes priority over acceptance:
  - out_valid = 0 and the input is dropped.
  - spec RAT = retire RAT, including commits applied this same cycle.
  - head = commit_head, post-update; count = (tail − head) mod 64, with 64 when they are equal and the list was full.
- head, tail and commit_head are 6-bit and wrap mod 64.

Test Plan:
- Reset, then an instruction with inputs {1,2,63} and outputs {3,63,63} -> next cycle: prn_inputs {1,2,127}, prn_outputs {63,127,127}, prn_old {3,127,127}, count 63.
- Back-to-back instructions writing ARN 5, then reading ARN 5 -> second instruction's source PRN = 63; a third writing ARN 5 gets PRN 65 with prn_old 64.
- Same instruction with outputs {7,7,63} -> prn_outputs {63,64}, prn_old {7,63}; RAT[7] = 64.
- 64 single-destination renames with no commits -> the 65th asserts stall_out. A commit freeing PRN 7 deasserts stall_out next cycle; the 65th then gets PRN 7.
- stall_in held 3 cycles with out_valid -> outputs constant, stall_out = 1, no pops.
- Rename ARN 4 -> 63, commit it (old 4 freed), rename ARN 4 -> 64, then flush -> RAT[4] = 63, head = 1, next allocation returns PRN 64.
